// File: rtl/fifo_flex_pkg.sv
// Shared constants and helpers for the fifo_flex buffer family.
package fifo_flex_pkg;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   // Pointers carry one extra wrap bit above the storage address.
   function automatic int ptr_width(input int depth_bits);
      return depth_bits + 1;
   endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// Dual-port distributed RAM: synchronous write, asynchronous read.
module fifo_flex_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_BITS  = 4
) (
   input  logic                  MCLK,
   input  logic                  i_we,
   input  logic [ADDR_BITS-1:0]  i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_BITS-1:0]  i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_BITS)-1];

   // NOTE: storage has no reset so it maps onto plain LUT RAM; stale words are never observable.
   always_ff @(posedge MCLK) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with level, programmable thresholds, sticky errors,
// flush and selectable registered or first-word-fall-through read.
module fifo_flex
   import fifo_flex_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH_BITS   = 4,
   parameter int AFULL_LEVEL  = (2 ** DEPTH_BITS) - 2,
   parameter int AEMPTY_LEVEL = 1,
   parameter int FWFT         = FWFT_OFF
) (
   input  logic                  MCLK,
   input  logic                  nRST,
   input  logic                  FLUSH,
   input  logic                  nWE,
   input  logic [DATA_WIDTH-1:0] DIN,
   output logic                  FULL,
   output logic                  AFULL,
   input  logic                  nRE,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic                  EMPTY,
   output logic                  AEMPTY,
   output logic [DEPTH_BITS:0]   LEVEL,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int DEPTH = 2 ** DEPTH_BITS;
   localparam int PTR_W = ptr_width(DEPTH_BITS);
   localparam logic [PTR_W-1:0] LVL_FULL   = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] LVL_AFULL  = PTR_W'(AFULL_LEVEL);
   localparam logic [PTR_W-1:0] LVL_AEMPTY = PTR_W'(AEMPTY_LEVEL);

   if (DEPTH_BITS < 1) begin : g_bad_depth
      $fatal(1, "fifo_flex: DEPTH_BITS must be >= 1");
   end
   if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
      $fatal(1, "fifo_flex: AFULL_LEVEL out of range");
   end
   if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL >= DEPTH) begin : g_bad_aempty
      $fatal(1, "fifo_flex: AEMPTY_LEVEL out of range");
   end
   if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_fwft
      $fatal(1, "fifo_flex: FWFT must be 0 or 1");
   end

   logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr, r_level;
   logic                  r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
   logic                  w_push_ok, w_pop_ok;
   logic [PTR_W-1:0]      w_wr_ptr_nxt, w_rd_ptr_nxt, w_level_nxt;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // Flush wins over both requests, so neither transfer is accepted during it.
   assign w_push_ok = !nWE && !r_full  && !FLUSH;
   assign w_pop_ok  = !nRE && !r_empty && !FLUSH;

   assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push_ok);
   assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop_ok);
   // The wrap bit makes the modular pointer difference an exact 0..DEPTH count.
   assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge MCLK or negedge nRST) begin
      if (!nRST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (FLUSH) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_afull  <= (LVL_AFULL == '0);
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         r_full   <= (w_level_nxt == LVL_FULL);
         r_afull  <= (w_level_nxt >= LVL_AFULL);
         r_empty  <= (w_level_nxt == '0);
         r_aempty <= (w_level_nxt <= LVL_AEMPTY);
         r_ovf    <= r_ovf | (!nWE && r_full);
         r_udf    <= r_udf | (!nRE && r_empty);
      end
   end

   fifo_flex_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (DEPTH_BITS)
   ) u_mem (
      .MCLK    (MCLK),
      .i_we    (w_push_ok),
      .i_waddr (r_wr_ptr[DEPTH_BITS-1:0]),
      .i_wdata (DIN),
      .i_raddr (r_rd_ptr[DEPTH_BITS-1:0]),
      .o_rdata (w_rd_data)
   );

   if (FWFT == FWFT_ON) begin : g_fwft
      assign DOUT = w_rd_data;
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_dout;
      always_ff @(posedge MCLK or negedge nRST) begin
         if (!nRST)         r_dout <= '0;
         else if (w_pop_ok) r_dout <= w_rd_data;
      end
      assign DOUT = r_dout;
   end

   assign FULL      = r_full;
   assign AFULL     = r_afull;
   assign EMPTY     = r_empty;
   assign AEMPTY    = r_aempty;
   assign LEVEL     = r_level;
   assign OVERFLOW  = r_ovf;
   assign UNDERFLOW = r_udf;

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: a registered-read instance and an FWFT instance, DEPTH=4.
module tb_fifo_flex;

   localparam int DW = 8;
   localparam int DEPTH = 4;

   logic          MCLK, nRST;
   logic          FLUSH, nWE, nRE;
   logic [DW-1:0] DIN, DOUT;
   logic          FULL, AFULL, EMPTY, AEMPTY, OVERFLOW, UNDERFLOW;
   logic [2:0]    LEVEL;

   logic          fw_flush, fw_nwe, fw_nre;
   logic [DW-1:0] fw_din, fw_dout;
   logic          fw_full, fw_afull, fw_empty, fw_aempty, fw_ovf, fw_udf;
   logic [2:0]    fw_level;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] m_dout;
   bit            m_ovf, m_udf;

   fifo_flex #(.DATA_WIDTH(DW), .DEPTH_BITS(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(0)) u_dut (
      .MCLK(MCLK), .nRST(nRST), .FLUSH(FLUSH), .nWE(nWE), .DIN(DIN), .FULL(FULL), .AFULL(AFULL),
      .nRE(nRE), .DOUT(DOUT), .EMPTY(EMPTY), .AEMPTY(AEMPTY), .LEVEL(LEVEL),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   fifo_flex #(.DATA_WIDTH(DW), .DEPTH_BITS(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1)) u_dut_fw (
      .MCLK(MCLK), .nRST(nRST), .FLUSH(fw_flush), .nWE(fw_nwe), .DIN(fw_din), .FULL(fw_full),
      .AFULL(fw_afull), .nRE(fw_nre), .DOUT(fw_dout), .EMPTY(fw_empty), .AEMPTY(fw_aempty),
      .LEVEL(fw_level), .OVERFLOW(fw_ovf), .UNDERFLOW(fw_udf)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      int lvl;
      lvl = sb_q.size();
      check({tag, ".level"},  32'(LEVEL), lvl);
      check({tag, ".empty"},  32'(EMPTY), 32'(lvl == 0));
      check({tag, ".full"},   32'(FULL), 32'(lvl == DEPTH));
      check({tag, ".afull"},  32'(AFULL), 32'(lvl >= 3));
      check({tag, ".aempty"}, 32'(AEMPTY), 32'(lvl <= 1));
      check({tag, ".ovf"},    32'(OVERFLOW), 32'(m_ovf));
      check({tag, ".udf"},    32'(UNDERFLOW), 32'(m_udf));
      check({tag, ".dout"},   32'(DOUT), 32'(m_dout));
   endtask

   // One clock of stimulus on the registered-read instance; the scoreboard predicts the result.
   task automatic do_cycle(input string tag, input bit we, input bit re, input bit fl, input logic [DW-1:0] d);
      int lvl;
      bit push_ok, pop_ok;
      lvl     = sb_q.size();
      nWE     = !we;
      nRE     = !re;
      FLUSH   = fl;
      DIN     = d;
      push_ok = we && (lvl < DEPTH) && !fl;
      pop_ok  = re && (lvl > 0) && !fl;
      if (fl) begin
         sb_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (we && lvl == DEPTH) m_ovf = 1'b1;
         if (re && lvl == 0)     m_udf = 1'b1;
         if (pop_ok)  m_dout = sb_q.pop_front();
         if (push_ok) sb_q.push_back(d);
      end
      @(posedge MCLK);
      #1;
      check_state(tag);
      nWE   = 1'b1;
      nRE   = 1'b1;
      FLUSH = 1'b0;
   endtask

   initial begin
      nRST = 1'b0;
      FLUSH = 1'b0; nWE = 1'b1; nRE = 1'b1; DIN = '0;
      fw_flush = 1'b0; fw_nwe = 1'b1; fw_nre = 1'b1; fw_din = '0;
      m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
      repeat (2) @(posedge MCLK);
      @(negedge MCLK);
      nRST = 1'b1;
      #1;
      check_state("reset");
      check("reset.fw_level", 32'(fw_level), 0);
      check("reset.fw_empty", 32'(fw_empty), 1);
      check("reset.fw_aempty", 32'(fw_aempty), 1);
      check("reset.fw_full", 32'(fw_full), 0);
      check("reset.fw_afull", 32'(fw_afull), 0);
      check("reset.fw_ovf", 32'(fw_ovf), 0);
      check("reset.fw_udf", 32'(fw_udf), 0);

      // Fill to full, then one dropped push.
      for (int i = 0; i < 4; i++) do_cycle("fill", 1'b1, 1'b0, 1'b0, DW'(8'h10 + i));
      do_cycle("overflow", 1'b1, 1'b0, 1'b0, 8'h14);

      // Drain in order, then one pop on empty.
      for (int i = 0; i < 4; i++) do_cycle("drain", 1'b0, 1'b1, 1'b0, '0);
      do_cycle("underflow", 1'b0, 1'b1, 1'b0, '0);
      do_cycle("flush_clear", 1'b0, 1'b0, 1'b1, '0);

      // Streaming across several pointer wraps at constant level.
      do_cycle("preload", 1'b1, 1'b0, 1'b0, 8'h20);
      do_cycle("preload", 1'b1, 1'b0, 1'b0, 8'h21);
      for (int i = 0; i < 12; i++) do_cycle("stream", 1'b1, 1'b1, 1'b0, DW'(8'h22 + i));
      for (int i = 0; i < 2; i++) do_cycle("stream_drain", 1'b0, 1'b1, 1'b0, '0);

      // Flush at level 3 with overflow set, while a push is requested.
      for (int i = 0; i < 5; i++) do_cycle("refill", 1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
      do_cycle("pop_to_3", 1'b0, 1'b1, 1'b0, '0);
      do_cycle("flush_push", 1'b1, 1'b0, 1'b1, 8'h99);
      do_cycle("post_flush_push", 1'b1, 1'b0, 1'b0, 8'h55);
      do_cycle("post_flush_pop", 1'b0, 1'b1, 1'b0, '0);

      // FWFT instance: head word appears without a pop.
      fw_nwe = 1'b0;
      fw_din = 8'hA5;
      @(posedge MCLK);
      #1;
      fw_nwe = 1'b1;
      check("fwft.empty", 32'(fw_empty), 0);
      check("fwft.level", 32'(fw_level), 1);
      check("fwft.dout", 32'(fw_dout), 32'h0000_00A5);
      fw_nre = 1'b0;
      @(posedge MCLK);
      #1;
      fw_nre = 1'b1;
      check("fwft_pop.empty", 32'(fw_empty), 1);
      check("fwft_pop.level", 32'(fw_level), 0);

      // Asynchronous reset in the middle of a fill with an error flag set.
      do_cycle("pre_rst_udf", 1'b0, 1'b1, 1'b0, '0);
      do_cycle("mid_fill", 1'b1, 1'b0, 1'b0, 8'h61);
      do_cycle("mid_fill", 1'b1, 1'b0, 1'b0, 8'h62);
      #2;
      nRST = 1'b0;
      #1;
      sb_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
      check_state("async_rst");
      @(negedge MCLK);
      nRST = 1'b1;
      do_cycle("after_rst", 1'b0, 1'b0, 1'b0, '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO, the next generation of the team's fixed-depth FIFO. It adds configurable depth and width, a live fill level, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer logic inside one MCLK domain. It is the standard buffer for processor and DMA data paths.

## Interface
Parameters:
- DATA_WIDTH, 32, word width.
- DEPTH_BITS, 4, log2 of the entry count. DEPTH = 2**DEPTH_BITS. Must be ≥ 1.
- AFULL_LEVEL, DEPTH-2, AFULL threshold. Must satisfy 1 ≤ AFULL_LEVEL ≤ DEPTH.
- AEMPTY_LEVEL, 1, AEMPTY threshold. Must satisfy 0 ≤ AEMPTY_LEVEL < DEPTH.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- MCLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear, active-high.
- nWE  in  1  push request, active-low.
- DIN  in  DATA_WIDTH  push data.
- FULL  out  1  LEVEL == DEPTH.
- AFULL  out  1  LEVEL ≥ AFULL_LEVEL.
- nRE  in  1  pop request, active-low.
- DOUT  out  DATA_WIDTH  pop data.
- EMPTY  out  1  LEVEL == 0.
- AEMPTY  out  1  LEVEL ≤ AEMPTY_LEVEL.
- LEVEL  out  DEPTH_BITS+1  number of stored words, 0..DEPTH.
- OVERFLOW  out  1  sticky: a push was attempted while FULL.
- UNDERFLOW  out  1  sticky: a pop was attempted while EMPTY.

## Operation
- Pointers are DEPTH_BITS+1 bits wide. The MSB is the wrap bit, and the low bits address storage.
- Push is accepted iff nWE=0 and FULL=0. There is no full-bypass: a push while FULL is dropped even if a pop is accepted in the same cycle.
- Pop is accepted iff nRE=0 and EMPTY=0.
- LEVEL update per cycle:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- A push while FULL sets OVERFLOW. A pop while EMPTY sets UNDERFLOW. Neither changes any other state.
- The sticky flags clear only on FLUSH or nRST.
- FLUSH has priority over push and pop in the same cycle. Both are ignored, and no error flag is set. FLUSH zeroes both pointers, LEVEL, OVERFLOW and UNDERFLOW. FLUSH does not change DOUT.
- FWFT=0: DOUT is a register. It loads the head word on an accepted pop and holds its value otherwise, including on a rejected pop.
- FWFT=1: DOUT = mem[rd_ptr] combinationally, showing the head word whenever EMPTY=0. An accepted pop advances to the next word. DOUT is don't-care while EMPTY=1.
- FULL, EMPTY, AFULL, AEMPTY and LEVEL are flop outputs, computed from the next LEVEL. There is no combinational path from nWE or nRE to any flag.
- Parameter violations stop elaboration with $fatal.

## Timing
- Reset values:
  - LEVEL = 0, EMPTY = 1, AEMPTY = 1, FULL = 0.
  - AFULL = 0.
  - OVERFLOW = 0, UNDERFLOW = 0.
  - DOUT = 0 in FWFT=0 mode.
  - Both pointers = 0.
- A push accepted at edge t is visible after edge t: EMPTY falls and LEVEL increments. A pop may be accepted at edge t+1.
- FWFT=0: a pop accepted at edge t gives valid DOUT after edge t, so data has 1-cycle read latency.
- FWFT=1: the head word is on DOUT in the cycle after the edge where EMPTY falls, with no pop needed.
- Sustained simultaneous push and pop runs at 1 word per cycle across pointer wrap, with LEVEL constant.
- An nRST assertion mid-operation clears everything asynchronously. Stored data is discarded.
- Storage is written at the push edge and read asynchronously.

## Structure
- Package fifo_flex_pkg holds:
  - the pointer-width function (DEPTH_BITS+1);
  - the read-mode constants FWFT_OFF = 0 and FWFT_ON = 1.
- Sub-module fifo_flex_mem: DEPTH×DATA_WIDTH dual-port distributed RAM with synchronous write and asynchronous read, and no reset.
- The top level holds pointers, LEVEL, flags and the DOUT register.

## Test plan
All scenarios use DEPTH_BITS=2 (DEPTH=4), AFULL_LEVEL=3 and AEMPTY_LEVEL=1 unless stated otherwise.
- Reset: after nRST is released, LEVEL=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0, DOUT=0.
- Fill:
  - Push 0x10..0x13 on consecutive cycles. LEVEL steps 1, 2, 3, 4. AEMPTY falls at LEVEL=2, AFULL rises at 3, FULL rises at 4.
  - A 5th push of 0x14 is dropped: OVERFLOW=1, LEVEL stays 4.
- Drain, FWFT=0:
  - Four pops return DOUT 0x10, 0x11, 0x12, 0x13, each 1 cycle after its accepted pop.
  - A 5th pop sets UNDERFLOW=1 and DOUT holds 0x13.
- Streaming: preload 2 words, then push and pop simultaneously for 12 cycles. LEVEL stays 2, and the output sequence matches the input order across 3 pointer wraps.
- FWFT=1: push 0xA5 alone. The next cycle shows EMPTY=0 and DOUT=0xA5 with nRE=1. One pop returns EMPTY=1 and LEVEL=0.
- Flush and reset:
  - At LEVEL=3 with OVERFLOW=1, assert FLUSH together with nWE=0. The next cycle shows LEVEL=0, EMPTY=1, OVERFLOW=0, and the pushed word is discarded.
  - Separately, assert nRST asynchronously mid-fill. All outputs return to their reset values before the next edge.
